// File: rtl/nanorv32_ahb_arbiter.sv
// Two-master (I-side prefetch / D-side load-store) AHB-lite arbiter onto one slave port.
// Address phase is combinational from the grant; losers park in a one-deep per-master slot.
module nanorv32_ahb_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] haddri,
  input  logic              htransi,
  input  logic [2:0]        hsizei,
  output logic [DATA_W-1:0] hrdatai,
  output logic              hreadyi,
  output logic              hrespi,
  input  logic [ADDR_W-1:0] haddrd,
  input  logic              htransd,
  input  logic [2:0]        hsized,
  input  logic              hwrited,
  input  logic [DATA_W-1:0] hwdatad,
  output logic [DATA_W-1:0] hrdatad,
  output logic              hreadyd,
  output logic              hrespd,
  output logic [ADDR_W-1:0] haddrs,
  output logic [1:0]        htranss,
  output logic [2:0]        hsizes,
  output logic              hwrites,
  output logic [DATA_W-1:0] hwdatas,
  output logic              hmasters,
  input  logic [DATA_W-1:0] hrdatas,
  input  logic              hreadys,
  input  logic              hresps
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic              pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic [ADDR_W-1:0] pend_i_addr_q, pend_i_addr_d, pend_d_addr_q, pend_d_addr_d;
  logic [2:0]        pend_i_size_q, pend_i_size_d, pend_d_size_q, pend_d_size_d;
  logic              pend_d_write_q, pend_d_write_d;
  logic              dp_valid_q, dp_valid_d, dp_owner_q, dp_owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d, hmaster_q, hmaster_d;

  logic rdy_i, rdy_d, live_i, live_d, req_i, req_d, arb_en, gnt_i, gnt_d;

  always_comb begin
    rdy_i = 1'b1;
    if (pend_i_q)                      rdy_i = 1'b0;
    else if (dp_valid_q && !dp_owner_q) rdy_i = hreadys;
    rdy_d = 1'b1;
    if (pend_d_q)                      rdy_d = 1'b0;
    else if (dp_valid_q && dp_owner_q) rdy_d = hreadys;
  end

  assign live_i = htransi & rdy_i;
  assign live_d = htransd & rdy_d;
  assign req_i  = pend_i_q | live_i;
  assign req_d  = pend_d_q | live_d;
  assign arb_en = hreadys & ~rst;
  // D has priority unless I has been kept waiting STARVE_MAX cycles
  assign gnt_i  = arb_en & req_i & ((starve_q == STARVE_LIM) | ~req_d);
  assign gnt_d  = arb_en & req_d & ~gnt_i;

  always_comb begin
    haddr_d   = haddr_q;
    hsize_d   = hsize_q;
    hwrite_d  = hwrite_q;
    hmaster_d = hmaster_q;
    if (gnt_d) begin
      haddr_d   = pend_d_q ? pend_d_addr_q  : haddrd;
      hsize_d   = pend_d_q ? pend_d_size_q  : hsized;
      hwrite_d  = pend_d_q ? pend_d_write_q : hwrited;
      hmaster_d = 1'b1;
    end else if (gnt_i) begin
      haddr_d   = pend_i_q ? pend_i_addr_q : haddri;
      hsize_d   = pend_i_q ? pend_i_size_q : hsizei;
      hwrite_d  = 1'b0;
      hmaster_d = 1'b0;
    end
  end

  assign haddrs   = haddr_d;
  assign hsizes   = hsize_d;
  assign hwrites  = hwrite_d;
  assign hmasters = hmaster_d;
  assign htranss  = (gnt_i | gnt_d) ? 2'b10 : 2'b00;

  assign hrdatai = hrdatas;
  assign hrdatad = hrdatas;
  assign hreadyi = rdy_i;
  assign hreadyd = rdy_d;
  assign hrespi  = dp_valid_q & ~dp_owner_q & hresps;
  assign hrespd  = dp_valid_q &  dp_owner_q & hresps;
  assign hwdatas = (dp_valid_q && dp_owner_q) ? hwdatad : '0;

  always_comb begin
    pend_i_d       = pend_i_q;
    pend_i_addr_d  = pend_i_addr_q;
    pend_i_size_d  = pend_i_size_q;
    pend_d_d       = pend_d_q;
    pend_d_addr_d  = pend_d_addr_q;
    pend_d_size_d  = pend_d_size_q;
    pend_d_write_d = pend_d_write_q;
    dp_valid_d     = dp_valid_q;
    dp_owner_d     = dp_owner_q;
    starve_d       = starve_q;
    // An idle master sees hready=1 even during slave wait states, so its request must be parked
    if (gnt_i) pend_i_d = 1'b0;
    else if (live_i) begin
      pend_i_d      = 1'b1;
      pend_i_addr_d = haddri;
      pend_i_size_d = hsizei;
    end
    if (gnt_d) pend_d_d = 1'b0;
    else if (live_d) begin
      pend_d_d       = 1'b1;
      pend_d_addr_d  = haddrd;
      pend_d_size_d  = hsized;
      pend_d_write_d = hwrited;
    end
    if (hreadys) begin
      dp_valid_d = gnt_i | gnt_d;
      if (gnt_i | gnt_d) dp_owner_d = gnt_d;
      if (gnt_i)                                starve_d = '0;
      else if (req_i && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_i_q       <= 1'b0;
      pend_i_addr_q  <= '0;
      pend_i_size_q  <= '0;
      pend_d_q       <= 1'b0;
      pend_d_addr_q  <= '0;
      pend_d_size_q  <= '0;
      pend_d_write_q <= 1'b0;
      dp_valid_q     <= 1'b0;
      dp_owner_q     <= 1'b0;
      starve_q       <= '0;
      haddr_q        <= '0;
      hsize_q        <= '0;
      hwrite_q       <= 1'b0;
      hmaster_q      <= 1'b0;
    end else begin
      pend_i_q       <= pend_i_d;
      pend_i_addr_q  <= pend_i_addr_d;
      pend_i_size_q  <= pend_i_size_d;
      pend_d_q       <= pend_d_d;
      pend_d_addr_q  <= pend_d_addr_d;
      pend_d_size_q  <= pend_d_size_d;
      pend_d_write_q <= pend_d_write_d;
      dp_valid_q     <= dp_valid_d;
      dp_owner_q     <= dp_owner_d;
      starve_q       <= starve_d;
      haddr_q        <= haddr_d;
      hsize_q        <= hsize_d;
      hwrite_q       <= hwrite_d;
      hmaster_q      <= hmaster_d;
    end
  end

endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// Bench for nanorv32_ahb_arbiter: per-cycle vector table through a scoreboard queue,
// plus a hand-driven starvation sequence.
module tb_nanorv32_ahb_arbiter;

  logic        clk, rst;
  logic [31:0] haddri, haddrd, hwdatad, hrdatas;
  logic        htransi, htransd, hwrited, hreadys, hresps;
  logic [2:0]  hsizei, hsized;
  logic [31:0] hrdatai, hrdatad, haddrs, hwdatas;
  logic        hreadyi, hrespi, hreadyd, hrespd, hwrites, hmasters;
  logic [1:0]  htranss;
  logic [2:0]  hsizes;

  int checks = 0;
  int errors = 0;

  nanorv32_ahb_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .haddri(haddri), .htransi(htransi), .hsizei(hsizei),
    .hrdatai(hrdatai), .hreadyi(hreadyi), .hrespi(hrespi),
    .haddrd(haddrd), .htransd(htransd), .hsized(hsized), .hwrited(hwrited),
    .hwdatad(hwdatad), .hrdatad(hrdatad), .hreadyd(hreadyd), .hrespd(hrespd),
    .haddrs(haddrs), .htranss(htranss), .hsizes(hsizes), .hwrites(hwrites),
    .hwdatas(hwdatas), .hmasters(hmasters),
    .hrdatas(hrdatas), .hreadys(hreadys), .hresps(hresps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, ti, td, wd, rdy, resp;
    logic [31:0] ai, ad, wdat, rdat;
    logic [1:0]  e_trans;
    logic [31:0] e_addr, e_wdata;
    logic        e_write, e_master, e_rdyi, e_rdyd, e_respi, e_respd;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input string n, input logic r, input logic ti, input logic [31:0] ai,
                              input logic td, input logic [31:0] ad, input logic wd,
                              input logic [31:0] wdat, input logic rdy, input logic resp,
                              input logic [1:0] et, input logic [31:0] ea, input logic ew,
                              input logic em, input logic eri, input logic erd,
                              input logic epi, input logic epd, input logic [31:0] ewd);
    vec_t v;
    v.name = n; v.rst = r; v.ti = ti; v.ai = ai; v.td = td; v.ad = ad; v.wd = wd;
    v.wdat = wdat; v.rdy = rdy; v.resp = resp; v.rdat = '0;
    v.e_trans = et; v.e_addr = ea; v.e_write = ew; v.e_master = em;
    v.e_rdyi = eri; v.e_rdyd = erd; v.e_respi = epi; v.e_respd = epd; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; htransi = v.ti; haddri = v.ai; htransd = v.td; haddrd = v.ad;
    hwrited = v.wd; hwdatad = v.wdat; hreadys = v.rdy; hresps = v.resp; hrdatas = v.rdat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v, e;
    int found;
    logic [31:0] i_addr;

    rst = 1'b1; htransi = 0; htransd = 0; haddri = 0; haddrd = 0; hwrited = 0;
    hwdatad = 0; hreadys = 1; hresps = 0; hrdatas = 0; hsizei = 3'd2; hsized = 3'd2;

    //                name        rst ti ai          td ad          wd wdat          rdy rsp  trans addr         w  m  ri rd pi pd wdata
    tbl.push_back(mk("reset",      1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h0,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("idle",       0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h0,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("i_str0",     0, 1, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b10, 32'h0,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("i_str4",     0, 1, 32'h4,     0, 32'h0,     0, 32'h0,        1, 0,  2'b10, 32'h4,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("i_str8",     0, 1, 32'h8,     0, 32'h0,     0, 32'h0,        1, 0,  2'b10, 32'h8,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("i_tail",     0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h8,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("coll_d",     0, 1, 32'h100,   1, 32'h2000,  1, 32'h0,        1, 0,  2'b10, 32'h2000,  1, 1, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("coll_i",     0, 1, 32'h100,   0, 32'h0,     0, 32'hDEADBEEF, 1, 0,  2'b10, 32'h100,   0, 0, 0, 1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("coll_tail",  0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h100,   0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("ws_addr",    0, 0, 32'h0,     1, 32'h3000,  0, 32'h0,        1, 0,  2'b10, 32'h3000,  0, 1, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("ws_w1",      0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 0,  2'b00, 32'h3000,  0, 1, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ws_w2",      0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 0,  2'b00, 32'h3000,  0, 1, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ws_w3",      0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 0,  2'b00, 32'h3000,  0, 1, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ws_done",    0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h3000,  0, 1, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("err_addr",   0, 0, 32'h0,     1, 32'h4000,  0, 32'h0,        1, 0,  2'b10, 32'h4000,  0, 1, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("err_c1",     0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0, 1,  2'b00, 32'h4000,  0, 1, 1, 0, 0, 1, 32'h0));
    tbl.push_back(mk("err_c2",     0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 1,  2'b00, 32'h4000,  0, 1, 1, 1, 0, 1, 32'h0));
    tbl.push_back(mk("err_nodp",   0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 1,  2'b00, 32'h4000,  0, 1, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("rst_setup",  0, 1, 32'h500,   1, 32'h6000,  0, 32'h0,        1, 0,  2'b10, 32'h6000,  0, 1, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("rst_async",  1, 1, 32'h500,   0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h0,     0, 0, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk("rst_after",  0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1, 0,  2'b00, 32'h0,     0, 0, 1, 1, 0, 0, 32'h0));

    foreach (tbl[k]) begin
      v = tbl[k];
      v.rdat = 32'hA500_0000 + 32'(k);
      @(posedge clk);
      #1;
      drive(v);
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, ".htranss"},  32'(htranss),  32'(e.e_trans));
      chk({e.name, ".haddrs"},   haddrs,        e.e_addr);
      chk({e.name, ".hwrites"},  32'(hwrites),  32'(e.e_write));
      chk({e.name, ".hmasters"}, 32'(hmasters), 32'(e.e_master));
      chk({e.name, ".hreadyi"},  32'(hreadyi),  32'(e.e_rdyi));
      chk({e.name, ".hreadyd"},  32'(hreadyd),  32'(e.e_rdyd));
      chk({e.name, ".hrespi"},   32'(hrespi),   32'(e.e_respi));
      chk({e.name, ".hrespd"},   32'(hrespd),   32'(e.e_respd));
      chk({e.name, ".hwdatas"},  hwdatas,       e.e_wdata);
      chk({e.name, ".hrdatai"},  hrdatai,       e.rdat);
      chk({e.name, ".hrdatad"},  hrdatad,       e.rdat);
    end

    // Starvation: D requests every cycle, I continuously; I must win after 4 losses.
    found  = -1;
    i_addr = '0;
    for (int c = 0; c < 16 && found < 0; c++) begin
      @(posedge clk);
      #1;
      rst = 0; hreadys = 1; hresps = 0;
      htransi = 1; haddri = 32'h700;
      htransd = 1; haddrd = 32'h8000 + 32'(4 * c); hwrited = 0;
      @(negedge clk);
      if (htranss == 2'b10 && hmasters == 1'b0) begin
        found  = c;
        i_addr = haddrs;
      end else begin
        chk("starve.d_wins_trans",  32'(htranss),  32'(2'b10));
        chk("starve.d_wins_master", 32'(hmasters), 32'd1);
      end
    end
    chk("starve.wait_cycles", 32'(found), 32'd4);
    chk("starve.i_addr",      i_addr,     32'h700);

    @(posedge clk);
    #1;
    haddrd = 32'h8014;
    @(negedge clk);
    chk("resume.htranss",  32'(htranss),  32'(2'b10));
    chk("resume.hmasters", 32'(hmasters), 32'd1);
    chk("resume.haddrs",   haddrs,        32'h8010);
    chk("resume.hreadyd",  32'(hreadyd),  32'd0);
    chk("resume.hreadyi",  32'(hreadyi),  32'd1);

    @(posedge clk);
    #1;
    htransi = 0; htransd = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
